// File: rtl/display_pkg.sv
// Shared types and default field widths for the display source selector and the time/alarm counters.
package display_pkg;

   typedef enum logic [1:0] {
      HOME = 2'd0,
      ALT  = 2'd1,
      EDIT = 2'd2
   } state_e;

   localparam logic [1:0] EDIT_NONE = 2'd0;
   localparam logic [1:0] EDIT_MIN  = 2'd1;
   localparam logic [1:0] EDIT_HOUR = 2'd2;

   localparam int unsigned DISP_MIN_W  = 7;
   localparam int unsigned DISP_HOUR_W = 5;

endpackage

// File: rtl/display_source_mux_if.sv
// Key/mode inputs, packed hh:mm sources and the registered display outputs.
interface display_source_mux_if #(
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned MIN_W   = 7,
   parameter int unsigned HOUR_W  = 5
);
   localparam int unsigned SEL_W = $clog2(NUM_SRC);

   logic                       tick;
   logic [SEL_W-1:0]           mode;
   logic [1:0]                 edit_sel;
   logic                       key_act;
   logic [NUM_SRC*MIN_W-1:0]   min_in;
   logic [NUM_SRC*HOUR_W-1:0]  hour_in;
   logic [MIN_W-1:0]           min_out;
   logic [HOUR_W-1:0]          hour_out;
   logic                       min_blank;
   logic                       hour_blank;
   logic [SEL_W-1:0]           src_out;
   logic                       timeout_p;

   modport master (
      output tick, mode, edit_sel, key_act, min_in, hour_in,
      input  min_out, hour_out, min_blank, hour_blank, src_out, timeout_p
   );

   modport slave (
      input  tick, mode, edit_sel, key_act, min_in, hour_in,
      output min_out, hour_out, min_blank, hour_blank, src_out, timeout_p
   );

endinterface

// File: rtl/disp_blink_timer.sv
// Blink phase for the edited field and key-inactivity counter.
// Counter and expire exist only when DISP_AUTORETURN_EN is defined.
module disp_blink_timer #(
   parameter int unsigned TIMEOUT_TICKS = 30
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic key_act,
   input  logic mode_chg,
   input  logic in_edit,
   input  logic active,
   output logic phase,
   output logic expire
);

   // Phase sits at 0 outside EDIT, so entry into EDIT always starts dark-free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase <= 1'b0;
      end else if (!in_edit || key_act) begin
         phase <= 1'b0;
      end else if (tick) begin
         phase <= ~phase;
      end
   end

`ifdef DISP_AUTORETURN_EN
   localparam int unsigned    CNT_W   = $clog2(TIMEOUT_TICKS);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_TICKS - 1);

   logic [CNT_W-1:0] cnt_q;
   logic             at_max;

   assign at_max = (cnt_q == CNT_MAX);
   // A key press on the final tick wins over the timeout.
   assign expire = active & tick & at_max & ~key_act;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (key_act || mode_chg || !active) begin
         cnt_q <= '0;
      end else if (tick && !at_max) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end
`else
   logic unused_cfg;

   assign expire     = 1'b0;
   assign unused_cfg = &{1'b0, mode_chg, active, 32'(TIMEOUT_TICKS)};
`endif

endmodule

// File: rtl/display_source_mux.sv
// Registered hh:mm source selector with edit-field blink and optional auto-return to source 0.
// Auto-return (timeout counter, force flag, timeout_p) is built only with DISP_AUTORETURN_EN.
module display_source_mux
   import display_pkg::*;
#(
   parameter int unsigned NUM_SRC       = 4,
   parameter int unsigned MIN_W         = DISP_MIN_W,
   parameter int unsigned HOUR_W        = DISP_HOUR_W,
   parameter int unsigned TIMEOUT_TICKS = 30
) (
   input logic                 clk,
   input logic                 rst_n,
   display_source_mux_if.slave bus
);

   localparam int unsigned SEL_W = $clog2(NUM_SRC);

   state_e            state_q;
   state_e            state_d;
   logic              mode_chg;
   logic              force_c;
   logic              expire;
   logic              phase;
   logic              in_edit;
   logic              active;
   logic              edit_on;
   logic              src_zero;
   logic [SEL_W-1:0]  eff_src;
   logic [MIN_W-1:0]  min_sel;
   logic [HOUR_W-1:0] hour_sel;

`ifdef DISP_AUTORETURN_EN
   logic [SEL_W-1:0] mode_q;
   logic             force_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q  <= '0;
         force_q <= 1'b0;
      end else begin
         mode_q  <= bus.mode;
         force_q <= force_c;
      end
   end

   // Force takes effect on the expiring tick and drops as soon as mode moves.
   assign mode_chg = (bus.mode != mode_q);
   assign force_c  = expire | (force_q & ~mode_chg);
`else
   assign mode_chg = 1'b0;
   assign force_c  = 1'b0;
`endif

   assign eff_src  = (force_c || (32'(bus.mode) >= NUM_SRC)) ? '0 : bus.mode;
   assign src_zero = (eff_src == '0);
   assign edit_on  = (bus.edit_sel == EDIT_MIN) || (bus.edit_sel == EDIT_HOUR);
   assign in_edit  = (state_q == EDIT);
   assign active   = (state_q != HOME);

   disp_blink_timer #(
      .TIMEOUT_TICKS (TIMEOUT_TICKS)
   ) u_blink_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (bus.tick),
      .key_act  (bus.key_act),
      .mode_chg (mode_chg),
      .in_edit  (in_edit),
      .active   (active),
      .phase    (phase),
      .expire   (expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= HOME;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         HOME:    if (edit_on) state_d = EDIT; else if (!src_zero) state_d = ALT;
         ALT:     if (edit_on) state_d = EDIT; else if (src_zero)  state_d = HOME;
         EDIT:    if (!edit_on) state_d = src_zero ? HOME : ALT;
         default: state_d = HOME;
      endcase
      if (expire) state_d = HOME;
   end

   // Source mux over the packed hh:mm inputs.
   always_comb begin
      min_sel  = '0;
      hour_sel = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (eff_src == SEL_W'(i)) begin
            min_sel  = bus.min_in[i*MIN_W +: MIN_W];
            hour_sel = bus.hour_in[i*HOUR_W +: HOUR_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.min_out    <= '0;
         bus.hour_out   <= '0;
         bus.src_out    <= '0;
         bus.min_blank  <= 1'b0;
         bus.hour_blank <= 1'b0;
         bus.timeout_p  <= 1'b0;
      end else begin
         bus.min_out    <= min_sel;
         bus.hour_out   <= hour_sel;
         bus.src_out    <= eff_src;
         bus.min_blank  <= in_edit & phase & (bus.edit_sel == EDIT_MIN);
         bus.hour_blank <= in_edit & phase & (bus.edit_sel == EDIT_HOUR);
         bus.timeout_p  <= expire;
      end
   end

endmodule
